// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Types and constants shared by the program loader, its checksum accumulator
// and the top-level memory that the loader fills.
//   state_t        : loader FSM states
//   LOADER_DATA_W  : default memory word / stream byte width
//   LOADER_ADDR_W  : default memory address width
//   SUM_W          : width of the image checksum
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int LOADER_DATA_W = 8;
    localparam int LOADER_ADDR_W = 8;
    localparam int SUM_W         = 8;

endpackage

// File: rtl/sum8_acc.sv
// -----------------------------------------------------------------------------
// sum8_acc
// Modulo-256 byte accumulator used to verify a streamed image.
//   clock  : rising-edge clock
//   clear  : zero the running sum (wins over add_en)
//   add_en : add din to the running sum this cycle
//   din    : byte to add
//   sum    : running sum, modulo 2^SUM_W
// The sum has no reset: every image starts with a clear before any add.
// -----------------------------------------------------------------------------
module sum8_acc
    import loader_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             add_en,
    input  logic [SUM_W-1:0] din,
    output logic [SUM_W-1:0] sum
);

    always_ff @(posedge clock) begin
        if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a length-prefixed, checksummed byte stream (LEN, data..., CHK) into
// the processor memory starting at BASE_ADDR and holds the processor in reset
// until a complete, verified image is present.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_data/in_valid    : stream byte and its valid
//   in_ready            : loader accepts a byte this cycle
//   restart             : pulse to rearm from DONE or ERROR
//   mem_addr/data/wren  : registered memory write port (one write per byte)
//   cpu_hold            : processor held in reset, loader owns the memory
//   done / error        : image verified / checksum mismatch
//   count               : data bytes written in the current image
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int                DATA_W    = LOADER_DATA_W,
    parameter int                ADDR_W    = LOADER_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] count
);

    // One extra bit so a LEN of 0 can be held as 2^DATA_W bytes.
    localparam int REM_W = ADDR_W + 1;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   remaining_q;
    logic [ADDR_W-1:0]  wptr_q;
    logic [ADDR_W-1:0]  count_q;
    logic [ADDR_W-1:0]  wr_addr_p1;
    logic [DATA_W-1:0]  wr_data_p1;
    logic               vld_p1;
    logic [SUM_W-1:0]   sum;
    logic               xfer;
    logic               take_len;
    logic               take_data;
    logic               sum_ok;

    function automatic logic [REM_W-1:0] len_to_remaining(input logic [DATA_W-1:0] len);
        if (len == '0) begin
            return REM_W'(1) << DATA_W;
        end
        return REM_W'(len);
    endfunction

    assign xfer      = in_valid & in_ready;
    assign take_len  = xfer && (state_q == ST_IDLE);
    assign take_data = xfer && (state_q == ST_LOAD);
    assign sum_ok    = (in_data[SUM_W-1:0] == sum);

    sum8_acc u_sum (
        .clock  (clock),
        .clear  (take_len),
        .add_en (take_data),
        .din    (in_data[SUM_W-1:0]),
        .sum    (sum)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (take_len) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (take_data && (remaining_q == REM_W'(1))) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (xfer) state_d = sum_ok ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (restart) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (restart) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: accepted data byte becomes a registered memory write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vld_p1      <= 1'b0;
            wr_addr_p1  <= BASE_ADDR;
            wr_data_p1  <= '0;
            wptr_q      <= BASE_ADDR;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= take_data;
            if (take_len) begin
                remaining_q <= len_to_remaining(in_data);
                wptr_q      <= BASE_ADDR;
                count_q     <= '0;
            end
            if (take_data) begin
                wr_data_p1  <= in_data;
                wr_addr_p1  <= wptr_q;
                wptr_q      <= wptr_q + 1'b1;
                count_q     <= count_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign mem_addr = wr_addr_p1;
    assign mem_data = wr_data_p1;
    assign mem_wren = vld_p1;
    assign count    = count_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       restart;
    logic [7:0] in_data;

    logic       r0, wren0, hold0, done0, err0;
    logic [7:0] addr0, data0, cnt0;
    logic       r1, wren1, hold1, done1, err1;
    logic [7:0] addr1, data1, cnt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int wr0 = 0;
    int wr1 = 0;

    always #5 clock = ~clock;

    prog_loader #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r0), .restart(restart), .mem_addr(addr0), .mem_data(data0),
        .mem_wren(wren0), .cpu_hold(hold0), .done(done0), .error(err0), .count(cnt0)
    );

    prog_loader #(.DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'hF0)) u_dut_hi (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r1), .restart(restart), .mem_addr(addr1), .mem_data(data1),
        .mem_wren(wren1), .cpu_hold(hold1), .done(done1), .error(err1), .count(cnt1)
    );

    // Memory models: a write strobe is high for the whole cycle after acceptance.
    always @(negedge clock) begin
        if (wren0) begin
            mem0[addr0] <= data0;
            wr0 <= wr0 + 1;
        end
        if (wren1) begin
            mem1[addr1] <= data1;
            wr1 <= wr1 + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!r0) begin
            if (n == 20) begin
                check_eq("ready_timeout", 0, 1);
                break;
            end
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int base;
        int base1;
        logic [7:0] gap_vals [4];
        gap_vals[0] = 8'hA0;
        gap_vals[1] = 8'hB1;
        gap_vals[2] = 8'hC2;
        gap_vals[3] = 8'hD3;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check_eq("rst_in_ready", r0, 1);
        check_eq("rst_wren", wren0, 0);
        check_eq("rst_addr", addr0, 8'h00);
        check_eq("rst_data", data0, 8'h00);
        check_eq("rst_hold", hold0, 1);
        check_eq("rst_done", done0, 0);
        check_eq("rst_error", err0, 0);
        check_eq("rst_count", cnt0, 0);
        check_eq("rst_addr_hi", addr1, 8'hF0);

        // Basic load
        base = wr0;
        send_byte(8'h03);
        send_byte(8'h11);
        check_eq("lat_wren", wren0, 1);
        check_eq("lat_addr", addr0, 8'h00);
        check_eq("lat_data", data0, 8'h11);
        check_eq("lat_count", cnt0, 1);
        send_byte(8'h22);
        send_byte(8'h33);
        check_eq("basic_count", cnt0, 3);
        check_eq("basic_hold_pre", hold0, 1);
        check_eq("basic_done_pre", done0, 0);
        send_byte(8'h66);
        check_eq("basic_done", done0, 1);
        check_eq("basic_hold", hold0, 0);
        check_eq("basic_error", err0, 0);
        check_eq("basic_ready", r0, 0);
        check_eq("basic_writes", wr0 - base, 3);
        check_eq("basic_mem0", mem0[0], 8'h11);
        check_eq("basic_mem1", mem0[1], 8'h22);
        check_eq("basic_mem2", mem0[2], 8'h33);

        // in_valid held high while DONE
        base = wr0;
        in_data  = 8'h55;
        in_valid = 1'b1;
        idle(5);
        in_valid = 1'b0;
        check_eq("done_hold_writes", wr0 - base, 0);
        check_eq("done_hold_count", cnt0, 3);
        check_eq("done_hold_done", done0, 1);
        pulse_restart();
        check_eq("restart_done", done0, 0);
        check_eq("restart_ready", r0, 1);
        check_eq("restart_hold", hold0, 1);

        // Bad checksum
        base = wr0;
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h0A);
        check_eq("bad_error", err0, 1);
        check_eq("bad_hold", hold0, 1);
        check_eq("bad_ready", r0, 0);
        check_eq("bad_done", done0, 0);
        check_eq("bad_writes", wr0 - base, 2);
        check_eq("bad_mem0", mem0[0], 8'h05);
        check_eq("bad_mem1", mem0[1], 8'h06);
        pulse_restart();
        check_eq("bad_restart_error", err0, 0);
        check_eq("bad_restart_ready", r0, 1);

        // restart during LOAD is ignored
        send_byte(8'h02);
        send_byte(8'h07);
        pulse_restart();
        send_byte(8'h08);
        send_byte(8'h0F);
        check_eq("rload_done", done0, 1);
        check_eq("rload_count", cnt0, 2);
        check_eq("rload_mem1", mem0[1], 8'h08);
        pulse_restart();

        // Gaps in in_valid
        base = wr0;
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 3));
            send_byte(gap_vals[i]);
        end
        idle(2);
        send_byte(8'hE6);
        check_eq("gap_done", done0, 1);
        check_eq("gap_count", cnt0, 4);
        check_eq("gap_writes", wr0 - base, 4);
        check_eq("gap_mem0", mem0[0], 8'hA0);
        check_eq("gap_mem3", mem0[3], 8'hD3);
        pulse_restart();

        // Reset mid-load
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        check_eq("mid_pending_wren", wren0, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("mid_wren", wren0, 0);
        check_eq("mid_addr", addr0, 8'h00);
        check_eq("mid_data", data0, 8'h00);
        check_eq("mid_count", cnt0, 0);
        check_eq("mid_hold", hold0, 1);
        check_eq("mid_ready", r0, 1);
        base = wr0;
        idle(3);
        check_eq("mid_no_writes", wr0 - base, 0);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5A);
        check_eq("fresh_done", done0, 1);
        check_eq("fresh_count", cnt0, 1);
        check_eq("fresh_mem0", mem0[0], 8'h5A);
        pulse_restart();

        // LEN 0 (256 bytes) with address wrap on the high-base instance
        base1 = wr1;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
        end
        check_eq("wrap_count", cnt1, 0);
        check_eq("wrap_done_pre", done1, 0);
        send_byte(8'h80);
        check_eq("wrap_done", done1, 1);
        check_eq("wrap_hold", hold1, 0);
        check_eq("wrap_error", err1, 0);
        check_eq("wrap_writes", wr1 - base1, 256);
        check_eq("wrap_last_addr", addr1, 8'hEF);
        check_eq("wrap_mem_ef", mem1[8'hEF], 8'hFF);
        check_eq("wrap_mem_f0", mem1[8'hF0], 8'h00);
        check_eq("wrap_mem_0f", mem1[8'h0F], 8'h1F);
        check_eq("wrap_lo_done", done0, 1);
        check_eq("wrap_lo_mem_ff", mem0[8'hFF], 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the multicycle processor's dual-port memory. It receives a length-prefixed, checksummed image over a valid/ready byte interface and writes it into the memory's data port starting at `BASE_ADDR`. It holds the processor in reset (`cpu_hold`) until a complete, checksum-verified image is in memory. It sits beside the processor: its write port is muxed onto the memory's `address`, `data` and `wren` while `cpu_hold` is high.

## Interface
Parameters:
- `DATA_W`, 8: byte width; must match memory word width.
- `ADDR_W`, 8: memory address width.
- `BASE_ADDR`, 0: address of the first image byte.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; one clock, and reset is synchronous and active-high.
- `in_data`  in  DATA_W: stream byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `restart`  in  1: single-cycle pulse; rearms the loader from DONE or ERROR.
- `mem_addr`  out  ADDR_W: write address.
- `mem_data`  out  DATA_W: write data.
- `mem_wren`  out  1: one-cycle write strobe.
- `cpu_hold`  out  1: holds the processor in reset and selects the loader memory path.
- `done`  out  1: image loaded and verified.
- `error`  out  1: checksum mismatch.
- `count`  out  ADDR_W: data bytes written so far; displayable on HEX.

## Operation
- Stream format: LEN, then the data bytes, then CHK.
  - LEN = 0 means 256 bytes; otherwise LEN bytes.
  - CHK = 8-bit sum, modulo 256, of all data bytes. LEN is not included in the sum.
- A byte transfer occurs on a rising edge where `in_valid & in_ready`.
- FSM states:
  - IDLE: `in_ready`=1. On transfer: latch `remaining` = LEN (0 becomes 256), `sum`=0, `wptr`=`BASE_ADDR`, `count`=0; go to LOAD.
  - LOAD: `in_ready`=1. On transfer:
    - register `mem_data`=byte and `mem_addr`=`wptr`; pulse `mem_wren` the next cycle;
    - `sum` += byte; `wptr` += 1, wrapping mod 2^ADDR_W; `count` += 1; `remaining` -= 1;
    - on the last byte go to CHECK.
  - CHECK: `in_ready`=1. On transfer: if byte == `sum`, go to DONE, else go to ERROR.
  - DONE: `in_ready`=0, `done`=1, `cpu_hold`=0. `restart` goes to IDLE.
  - ERROR: `in_ready`=0, `error`=1, `cpu_hold`=1. `restart` goes to IDLE.
- `restart` is ignored in IDLE, LOAD and CHECK.
- `in_valid` is ignored while `in_ready`=0; no byte is consumed.
- `cpu_hold` is 1 in every state except DONE.
- `remaining` is ADDR_W+1 bits wide so it can hold 256.
- Address wrap is silent: a load from BASE_ADDR=0xF0 with LEN=0x20 ends at 0x0F.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `mem_wren`=0, `mem_addr`=`BASE_ADDR`, `mem_data`=0, `cpu_hold`=1, `done`=0, `error`=0, `count`=0.
- Write latency: a data byte accepted at edge k is written at edge k+1 (`mem_wren` high between k and k+1).
- Throughput: one byte per cycle; gaps in `in_valid` are allowed anywhere.
- `mem_wren` is never high for two cycles per byte.
- `count` updates at the acceptance edge.
- The CHK byte accepted at edge k gives `done` or `error` high after edge k, and `cpu_hold` falls after edge k on success.
  - The last data write (edge k-1+1) completes no later than the CHK decision, so the processor never sees a partial image.
- `reset` mid-load: all outputs return to reset values on that edge. Any pending `mem_wren` is dropped. Memory contents already written are not cleared.
- `reset` and `restart` in the same cycle: `reset` wins.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, LOAD, CHECK, DONE, ERROR); default DATA_W/ADDR_W constants shared with the top-level memory.
- Sub-module `sum8_acc`: an 8-bit modulo-256 accumulator with `clear` and `add_en`. Reusable by any future image-verify logic.
- The top-level address/data/wren mux onto the memory is owned by the top level, not by this block.

## Test plan
- Basic load: stream 0x03, 0x11, 0x22, 0x33, CHK 0x66, BASE=0 -> writes 0x11@0, 0x22@1, 0x33@2; `done`=1, `cpu_hold`=0, `count`=3.
- Bad checksum: 0x02, 0x05, 0x06, CHK 0x0A -> both writes occur; `error`=1, `cpu_hold` stays 1, `in_ready`=0. A `restart` pulse then gives IDLE, `error`=0.
- Length 0 with wrap: BASE=0xF0, LEN=0x00, 256 bytes of value i -> last write is 0xFF@0xEF, `count` wraps to 0, CHK 0x80 gives `done`.
- Backpressure and gaps: random `in_valid` gaps; `in_valid` held high in DONE -> no extra writes, byte count exact.
- Reset mid-load: assert `reset` after the 2nd of 4 data bytes -> outputs at reset values next cycle, no further `mem_wren`; a fresh stream loads correctly.
- `restart` during LOAD is ignored -> the load continues and completes normally.
